// File: rtl/accel_conv_scheduler_if.sv
// Link between the conversion scheduler and the shared binary_to_ascii converter.
// The scheduler is the master: it issues start/operand and collects done/result.
interface accel_conv_scheduler_if #(
  parameter int DATA_W  = 13,
  parameter int ASCII_W = 32
);
  logic               conv_start;
  logic [DATA_W-1:0]  conv_bin;
  logic               conv_done;
  logic [ASCII_W-1:0] conv_ascii;
  logic               conv_neg;

  modport master (output conv_start, conv_bin, input conv_done, conv_ascii, conv_neg);
  modport slave  (input conv_start, conv_bin, output conv_done, conv_ascii, conv_neg);
endinterface

// File: rtl/accel_conv_scheduler.sv
// Shares one binary_to_ascii converter across the X/Y/Z/T channels: snapshot, convert
// round-robin, stage the results and publish the whole frame in a single cycle.
module accel_conv_scheduler #(
  parameter int DATA_W      = 13,
  parameter int ASCII_W     = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   accel_X,
  input  logic [DATA_W-1:0]   accel_Y,
  input  logic [DATA_W-1:0]   accel_Z,
  input  logic [DATA_W-1:0]   accel_T,
  accel_conv_scheduler_if.master conv,
  output logic [ASCII_W-1:0]  ascii_X,
  output logic [ASCII_W-1:0]  ascii_Y,
  output logic [ASCII_W-1:0]  ascii_Z,
  output logic [ASCII_W-1:0]  ascii_T,
  output logic                neg_X,
  output logic                neg_Y,
  output logic                neg_Z,
  output logic                neg_T,
  output logic                frame_valid,
  output logic                busy,
  output logic                overrun,
  output logic                timeout_err
);
  localparam int NUM_CH = 4;
  localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ASCII_W-1:0] ASCII_ZERO = {(ASCII_W/8){8'h30}};
  localparam logic [ASCII_W-1:0] ASCII_UNK  = {(ASCII_W/8){8'h3F}};

  typedef enum logic [2:0] {IDLE, START, WAIT, NEXT, PUBLISH} state_t;

  state_t                         state, state_nxt;
  logic [NUM_CH-1:0][DATA_W-1:0]  sample, snap;
  logic [NUM_CH-1:0][ASCII_W-1:0] pub_ascii;
  logic [NUM_CH-1:0]              pub_neg;
  logic [1:0]                     idx;
  logic [CNT_W-1:0]               cnt;
  logic                           timed_out;
  logic                           publish;

  assign sample    = {accel_T, accel_Z, accel_Y, accel_X};
  assign timed_out = (state == WAIT) && !conv.conv_done && (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign publish   = enable && (state == PUBLISH);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (enable) begin
      case (state)
        IDLE:    if (sample_valid) state_nxt = START;
        START:   state_nxt = WAIT;
        WAIT:    if (conv.conv_done || timed_out) state_nxt = NEXT;
        NEXT:    state_nxt = (idx == 2'd3) ? PUBLISH : START;
        PUBLISH: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    conv.conv_start = (state == START) && enable;
    busy            = (state != IDLE);
  end

  // conv_bin only moves on the way into START, so it is stable through the whole wait
  always_ff @(posedge clk) begin
    if (reset) begin
      snap          <= '0;
      idx           <= '0;
      cnt           <= '0;
      conv.conv_bin <= '0;
      frame_valid   <= 1'b0;
      overrun       <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      frame_valid <= publish;
      overrun     <= sample_valid && !((state == IDLE) && enable);
      if (enable) begin
        case (state)
          IDLE: if (sample_valid) begin
            snap          <= sample;
            idx           <= '0;
            conv.conv_bin <= sample[0];
          end
          START: cnt <= '0;
          WAIT: if (!conv.conv_done) begin
            cnt <= cnt + 1'b1;
            if (timed_out) timeout_err <= 1'b1;
          end
          NEXT: if (idx != 2'd3) begin
            idx           <= idx + 2'd1;
            conv.conv_bin <= snap[idx + 2'd1];
          end
          default: ;
        endcase
      end
    end
  end

  // Per-channel staging and published registers
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic               hit;
    logic [ASCII_W-1:0] st_ascii, pb_ascii;
    logic               st_neg, pb_neg;

    assign hit = enable && (state == WAIT) && (idx == 2'(c));

    always_ff @(posedge clk) begin
      if (reset) begin
        st_ascii <= '0;
        st_neg   <= 1'b0;
        pb_ascii <= ASCII_ZERO;
        pb_neg   <= 1'b0;
      end else begin
        if (hit && conv.conv_done) begin
          st_ascii <= conv.conv_ascii;
          st_neg   <= conv.conv_neg;
        end else if (hit && timed_out) begin
          st_ascii <= ASCII_UNK;
          st_neg   <= 1'b0;
        end
        if (publish) begin
          pb_ascii <= st_ascii;
          pb_neg   <= st_neg;
        end
      end
    end

    assign pub_ascii[c] = pb_ascii;
    assign pub_neg[c]   = pb_neg;
  end

  assign ascii_X = pub_ascii[0];
  assign ascii_Y = pub_ascii[1];
  assign ascii_Z = pub_ascii[2];
  assign ascii_T = pub_ascii[3];
  assign neg_X   = pub_neg[0];
  assign neg_Y   = pub_neg[1];
  assign neg_Z   = pub_neg[2];
  assign neg_T   = pub_neg[3];
endmodule

// File: tb/tb_accel_conv_scheduler.sv
// Directed bench for accel_conv_scheduler with a fixed-latency converter model.
module tb_accel_conv_scheduler;
  localparam int L = 20;

  typedef struct {
    logic [12:0] s [4];
    logic [31:0] a [4];
    logic [3:0]  n;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, enable, sample_valid;
  logic [12:0] ax, ay, az, at;
  logic [31:0] pa [4];
  logic [3:0]  pn;
  logic        frame_valid, busy, overrun, timeout_err;

  accel_conv_scheduler_if #(.DATA_W(13), .ASCII_W(32)) bus();

  accel_conv_scheduler #(.DATA_W(13), .ASCII_W(32), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
    .accel_X(ax), .accel_Y(ay), .accel_Z(az), .accel_T(at),
    .conv(bus),
    .ascii_X(pa[0]), .ascii_Y(pa[1]), .ascii_Z(pa[2]), .ascii_T(pa[3]),
    .neg_X(pn[0]), .neg_Y(pn[1]), .neg_Z(pn[2]), .neg_T(pn[3]),
    .frame_valid(frame_valid), .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit m_active = 0, m_suppress = 0;
  int m_cnt = 0, m_starts = 0, drop_ch = -1;
  logic [12:0] m_bin;
  logic [12:0] start_bins [4];
  vec_t vt [3];
  vec_t vto;

  function automatic logic [32:0] ref_conv(input logic [12:0] b);
    int v, m;
    v = int'($signed(b));
    m = (v < 0) ? -v : v;
    return {b[12], 8'h30 + 8'((m / 1000) % 10), 8'h30 + 8'((m / 100) % 10),
                   8'h30 + 8'((m / 10) % 10),   8'h30 + 8'(m % 10)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock; the converter model reacts to what the DUT shows in the new cycle.
  // enable still holds the previous cycle's value here, which is what the DUT saw.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bus.conv_done = 1'b0;
    if (reset) m_active = 0;
    if (bus.conv_start) begin
      if (m_starts < 4) start_bins[m_starts] = bus.conv_bin;
      m_suppress = (m_starts == drop_ch);
      m_starts++;
      m_active = 1;
      m_cnt    = 0;
      m_bin    = bus.conv_bin;
    end else if (m_active && enable) begin
      m_cnt++;
      if (m_cnt == L) begin
        m_active = 0;
        if (!m_suppress) begin
          {bus.conv_neg, bus.conv_ascii} = ref_conv(m_bin);
          bus.conv_done = 1'b1;
          chk("conv_bin_hold", 64'(bus.conv_bin), 64'(m_bin));
        end
      end
    end
  endtask

  task automatic run_frame(input vec_t v, input int sv2, input int sv3, input int en_off,
                           input int en_len, input int drop,
                           output int lat, output int ov_n, output int ov_first);
    m_starts = 0; drop_ch = drop; lat = -1; ov_n = 0; ov_first = -1;
    ax = v.s[0]; ay = v.s[1]; az = v.s[2]; at = v.s[3];
    sample_valid = 1'b1;
    enable = 1'b1;
    for (int c = 1; c <= 400 && lat < 0; c++) begin
      step();
      if (overrun) begin
        ov_n++;
        if (ov_first < 0) ov_first = c;
      end
      if (frame_valid) lat = c;
      sample_valid = (c == sv2) || (c == sv3);
      enable = !(c >= en_off && c < en_off + en_len);
      ax = 13'($urandom); ay = 13'($urandom); az = 13'($urandom); at = 13'($urandom);
    end
    sample_valid = 1'b0;
    enable = 1'b1;
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_wait: no frame_valid within 400 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic chk_frame(input vec_t v, input int lat, input int exp_lat);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("start_count", 64'(m_starts), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("conv_bin_ch%0d", i), 64'(start_bins[i]), 64'(v.s[i]));
      chk($sformatf("ascii_ch%0d", i), 64'(pa[i]), 64'(v.a[i]));
    end
    chk("neg", 64'(pn), 64'(v.n));
  endtask

  initial begin
    int lat, ovn, ovf, fv_cnt;

    vt[0].s = '{13'd1, 13'h1FFE, 13'd100, 13'd4095};
    vt[0].a = '{"0001", "0002", "0100", "4095"};
    vt[0].n = 4'b0010;
    vt[1].s = '{13'h1000, 13'd0, 13'h1FFF, 13'd2047};
    vt[1].a = '{"4096", "0000", "0001", "2047"};
    vt[1].n = 4'b0101;
    vt[2].s = '{13'd1234, 13'h1C19, 13'd42, 13'h1FF9};
    vt[2].a = '{"1234", "0999", "0042", "0007"};
    vt[2].n = 4'b1010;
    vto = vt[0];
    vto.a[2] = "????";

    reset = 1'b1; enable = 1'b1; sample_valid = 1'b0;
    ax = '0; ay = '0; az = '0; at = '0;
    bus.conv_done = 1'b0; bus.conv_ascii = '0; bus.conv_neg = 1'b0;
    step(); step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 4; i++) chk($sformatf("reset_ascii_ch%0d", i), 64'(pa[i]), 64'(32'h30303030));
    chk("reset_neg", 64'(pn), 64'd0);
    chk("reset_flags", 64'({frame_valid, busy, overrun, timeout_err, bus.conv_start}), 64'd0);
    chk("reset_conv_bin", 64'(bus.conv_bin), 64'd0);

    // Plain frames: latency 4*(L+2)+2 = 90
    for (int i = 0; i < 3; i++) begin
      run_frame(vt[i], -1, -1, -1, 0, -1, lat, ovn, ovf);
      chk_frame(vt[i], lat, 90);
      chk("no_overrun", 64'(ovn), 64'd0);
      step();
      chk("idle_after_frame", 64'({busy, frame_valid}), 64'd0);
    end
    chk("no_timeout_yet", 64'(timeout_err), 64'd0);

    // Overrun mid-frame and in the PUBLISH cycle; both samples dropped
    run_frame(vt[1], 10, 89, -1, 0, -1, lat, ovn, ovf);
    chk_frame(vt[1], lat, 90);
    chk("overrun_count", 64'(ovn), 64'd2);
    chk("overrun_first", 64'(ovf), 64'd11);
    step();
    chk("publish_sv_dropped", 64'({busy, bus.conv_start}), 64'd0);

    // Enable low for 15 cycles during Y's wait stretches the frame by 15
    run_frame(vt[2], -1, -1, 25, 15, -1, lat, ovn, ovf);
    chk_frame(vt[2], lat, 105);

    // Z never completes: 64 wait cycles instead of 20 adds 44
    run_frame(vt[0], -1, -1, -1, 0, 2, lat, ovn, ovf);
    chk_frame(vto, lat, 134);
    chk("timeout_err_set", 64'(timeout_err), 64'd1);
    step(); step();
    chk("timeout_err_sticky", 64'(timeout_err), 64'd1);

    // Reset during Z's wait aborts the frame
    m_starts = 0; drop_ch = -1;
    ax = vt[1].s[0]; ay = vt[1].s[1]; az = vt[1].s[2]; at = vt[1].s[3];
    sample_valid = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      step();
      sample_valid = 1'b0;
    end
    chk("busy_in_z_wait", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) chk($sformatf("midreset_ascii_ch%0d", i), 64'(pa[i]), 64'(32'h30303030));
    chk("midreset_state", 64'({pn, busy, frame_valid, timeout_err}), 64'd0);
    fv_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (frame_valid || busy) fv_cnt++;
    end
    chk("no_frame_after_reset", 64'(fv_cnt), 64'd0);

    run_frame(vt[0], -1, -1, -1, 0, -1, lat, ovn, ovf);
    chk_frame(vt[0], lat, 90);
    chk("timeout_err_cleared", 64'(timeout_err), 64'd0);

    // Spurious conv_done in IDLE is ignored
    step();
    bus.conv_done = 1'b1; bus.conv_ascii = "9999"; bus.conv_neg = 1'b1;
    step();
    chk("spurious_no_start", 64'({busy, bus.conv_start}), 64'd0);
    step(); step();
    for (int i = 0; i < 4; i++) chk($sformatf("spurious_ascii_ch%0d", i), 64'(pa[i]), 64'(vt[0].a[i]));
    chk("spurious_neg", 64'(pn), 64'(vt[0].n));
    chk("spurious_flags", 64'({busy, frame_valid, overrun}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
